// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 echo meter: FSM state encoding,
// distance scaling constants, default timing limits and the us->mm helper.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RISE = 3'd1,
        ST_MEASURE   = 3'd2,
        ST_DONE      = 3'd3,
        ST_WAIT_LOW  = 3'd4
    } meter_state_e;

    // dist_mm = (echo_us * DIST_SCALE) >> DIST_SHIFT  (~ echo_us * 0.1715)
    localparam logic [13:0] DIST_SCALE      = 14'd11240;
    localparam int unsigned DIST_SHIFT      = 16;

    localparam int unsigned ARM_WAIT_US_DEF = 1000;
    localparam int unsigned TIMEOUT_US_DEF  = 38000;

    // 16x14-bit product kept in 30 bits, then truncated by the shift.
    function automatic logic [15:0] us_to_mm(input logic [15:0] us);
        logic [29:0] prod;
        prod = {14'd0, us} * {16'd0, DIST_SCALE};
        return {2'b00, prod[29:DIST_SHIFT]};
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// 1 us tick generator: counts 0..DIV-1 and flags the terminal count.
// clr restarts the count so a new state always begins on a full microsecond.
module us_tick_gen #(
    parameter int unsigned DIV = 50
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TERM = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == TERM);

    // Next divider value: clear on request, wrap at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Divider register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/echo_meter.sv
// HC-SR04 echo meter: arms on the falling edge of trig, times the echo
// high pulse in microseconds and converts it to millimetres.
module echo_meter
    import hcsr04_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ = 50,
    parameter int unsigned ARM_WAIT_US  = ARM_WAIT_US_DEF,
    parameter int unsigned TIMEOUT_US   = TIMEOUT_US_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        trig,
    input  logic        echo,
    output logic [15:0] echo_us,
    output logic [15:0] dist_mm,
    output logic        dist_vld,
    output logic        timeout,
    output logic        busy
);

    localparam logic [15:0] ARM_LIM = 16'(ARM_WAIT_US);
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_US);

    meter_state_e state_q, state_d;

    logic        echo_s1_q, echo_s2_q, echo_s3_q;
    logic        trig_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] echo_us_q, echo_us_d;
    logic [15:0] dist_mm_q, dist_mm_d;
    logic        dist_vld_q, dist_vld_d;
    logic        timeout_q, timeout_d;
    logic        busy_q, busy_d;

    logic        tick_s;
    logic        tick_clr_s;
    logic        echo_rise_s;
    logic        echo_fall_s;
    logic        trig_fall_s;
    logic [15:0] cnt_inc_s;

    // Edges come from the synchronized echo only; s3 is its one-cycle history.
    assign echo_rise_s = echo_s2_q & ~echo_s3_q;
    assign echo_fall_s = ~echo_s2_q & echo_s3_q;
    assign trig_fall_s = trig_q & ~trig;
    assign cnt_inc_s   = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
    assign tick_clr_s  = (state_d != state_q);

    us_tick_gen #(
        .DIV (CLK_FREQ_MHZ)
    ) u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (tick_clr_s),
        .tick    (tick_s)
    );

    // Echo synchronizer chain plus trig history for edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            echo_s1_q <= 1'b0;
            echo_s2_q <= 1'b0;
            echo_s3_q <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_s3_q <= echo_s2_q;
            trig_q    <= trig;
        end
    end

    // Next state, microsecond counter and registered output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        echo_us_d  = echo_us_q;
        dist_mm_d  = dist_mm_q;
        dist_vld_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_fall_s) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise_s) begin
                    state_d = ST_MEASURE;
                    cnt_d   = 16'd0;
                end else if (cnt_q >= ARM_LIM) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else if (tick_s) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_MEASURE: begin
                // The falling edge is checked first so a pulse ending on the
                // timeout boundary still yields a valid measurement.
                if (echo_fall_s) begin
                    state_d = ST_DONE;
                    cnt_d   = tick_s ? cnt_inc_s : cnt_q;
                end else if (cnt_q >= TMO_LIM) begin
                    state_d   = ST_WAIT_LOW;
                    timeout_d = 1'b1;
                end else if (tick_s) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                echo_us_d  = cnt_q;
                dist_mm_d  = us_to_mm(cnt_q);
                dist_vld_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_WAIT_LOW: begin
                if (!echo_s2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LOW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            echo_us_q  <= 16'd0;
            dist_mm_q  <= 16'd0;
            dist_vld_q <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            echo_us_q  <= echo_us_d;
            dist_mm_q  <= dist_mm_d;
            dist_vld_q <= dist_vld_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign echo_us  = echo_us_q;
    assign dist_mm  = dist_mm_q;
    assign dist_vld = dist_vld_q;
    assign timeout  = timeout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_echo_meter.sv
// Testbench for echo_meter: table of directed measurements, hand-written
// timeout and reset sequences, then random pulses against a simple model.
module tb_echo_meter;

    localparam int F   = 2;     // clock MHz (kept small for short runs)
    localparam int ARM = 1000;
    localparam int TMO = 7000;

    typedef struct {
        bit pre_high;
        int delay_us;
        int width_us;   // 0 = no echo pulse at all
        bit mid_trig;
        int exp_vld;
        int exp_to;
        int exp_us;     // -1 = previous value must be kept
        int exp_mm;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        trig    = 1'b0;
    logic        echo    = 1'b0;
    logic [15:0] echo_us;
    logic [15:0] dist_mm;
    logic        dist_vld;
    logic        timeout;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, vld_cnt = 0, to_cnt = 0, to_cyc = 0, fall_cyc = 0;
    logic [15:0] vld_us = 16'd0, vld_mm = 16'd0;
    logic prev_vld = 1'b0, busy_after_vld = 1'b1;
    int prev_us = 0, prev_mm = 0;

    vec_t vecs[5];

    always #5 sys_clk = ~sys_clk;

    echo_meter #(
        .CLK_FREQ_MHZ (F),
        .ARM_WAIT_US  (ARM),
        .TIMEOUT_US   (TMO)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .trig     (trig),
        .echo     (echo),
        .echo_us  (echo_us),
        .dist_mm  (dist_mm),
        .dist_vld (dist_vld),
        .timeout  (timeout),
        .busy     (busy)
    );

    // Output monitor: counts pulses and captures values, away from posedge.
    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (dist_vld) begin
            vld_cnt <= vld_cnt + 1;
            vld_us  <= echo_us;
            vld_mm  <= dist_mm;
        end
        if (timeout) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
        end
        prev_vld <= dist_vld;
        if (prev_vld) busy_after_vld <= busy;
    end

    function automatic int model_mm(input int us);
        return (us * 11240) / 65536;
    endfunction

    task automatic check(input string name, input int act, input int exp, input int tol);
        n_tests++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic wait_us(input int us);
        repeat (us * F) @(negedge sys_clk);
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        wait_us(15);
        trig = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic drive_echo(input int width, input bit mid);
        echo = 1'b1;
        if (mid && width >= 40) begin
            wait_us(width / 2);
            trig = 1'b1;
            wait_us(15);
            trig = 1'b0;
            wait_us(width - width / 2 - 15);
        end else begin
            wait_us(width);
        end
        echo = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int v0, t0, eu, em;
        v0 = vld_cnt;
        t0 = to_cnt;
        if (v.pre_high) begin
            echo = 1'b1;
            wait_us(5);
            pulse_trig();
            wait_us(ARM + 20);
            echo = 1'b0;
            wait_us(5);
        end else begin
            pulse_trig();
            if (v.width_us == 0) begin
                wait_us(ARM + 20);
            end else begin
                wait_us(v.delay_us);
                drive_echo(v.width_us, v.mid_trig);
                wait_us(5);
            end
        end
        eu = (v.exp_us < 0) ? prev_us : v.exp_us;
        em = (v.exp_us < 0) ? prev_mm : v.exp_mm;
        check({tag, "/vld_count"}, vld_cnt - v0, v.exp_vld, 0);
        check({tag, "/timeout_count"}, to_cnt - t0, v.exp_to, 0);
        check({tag, "/echo_us"}, int'(echo_us), eu, 1);
        check({tag, "/dist_mm"}, int'(dist_mm), em, 1);
        check({tag, "/busy_idle"}, int'(busy), 0, 0);
        if (v.exp_vld != 0) begin
            check({tag, "/us_at_vld"}, int'(vld_us), eu, 1);
            check({tag, "/mm_at_vld"}, int'(vld_mm), em, 1);
            check({tag, "/busy_after_vld"}, int'(busy_after_vld), 0, 0);
            prev_us = eu;
            prev_mm = em;
        end else if (v.exp_to != 0 && v.width_us == 0 && !v.pre_high) begin
            check({tag, "/arm_timeout_time"}, to_cyc - fall_cyc, ARM * F, 6);
        end else begin
            prev_us = prev_us;
        end
    endtask

    initial begin
        int v0, t0, rise_cyc;
        vec_t rv;

        vecs[0] = '{1'b0, 200, 1000, 1'b0, 1, 0, 1000, 171};
        vecs[1] = '{1'b0, 200, 5800, 1'b0, 1, 0, 5800, 994};
        vecs[2] = '{1'b0, 300, 1200, 1'b1, 1, 0, 1200, 205};
        vecs[3] = '{1'b0, 0,    0,   1'b0, 0, 1, -1,   0};
        vecs[4] = '{1'b1, 0,    500, 1'b0, 0, 1, -1,   0};

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst/echo_us", int'(echo_us), 0, 0);
        check("rst/dist_mm", int'(dist_mm), 0, 0);
        check("rst/dist_vld", int'(dist_vld), 0, 0);
        check("rst/timeout", int'(timeout), 0, 0);
        check("rst/busy", int'(busy), 0, 0);
        sys_rst = 1'b0;
        wait_us(5);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Echo held past TIMEOUT_US: timeout pulse, old values kept, busy until low
        v0 = vld_cnt;
        t0 = to_cnt;
        pulse_trig();
        wait_us(100);
        echo = 1'b1;
        rise_cyc = cyc;
        wait_us(TMO + 50);
        check("tmo/timeout_count", to_cnt - t0, 1, 0);
        check("tmo/timeout_time", to_cyc - rise_cyc, TMO * F, 10);
        check("tmo/busy_while_high", int'(busy), 1, 0);
        check("tmo/echo_us_kept", int'(echo_us), prev_us, 0);
        check("tmo/dist_mm_kept", int'(dist_mm), prev_mm, 0);
        echo = 1'b0;
        wait_us(5);
        check("tmo/busy_after_low", int'(busy), 0, 0);
        check("tmo/no_vld", vld_cnt - v0, 0, 0);

        // Reset in the middle of a measurement
        pulse_trig();
        wait_us(200);
        echo = 1'b1;
        wait_us(500);
        check("mrst/busy_measuring", int'(busy), 1, 0);
        v0 = vld_cnt;
        t0 = to_cnt;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("mrst/echo_us", int'(echo_us), 0, 0);
        check("mrst/dist_mm", int'(dist_mm), 0, 0);
        check("mrst/busy", int'(busy), 0, 0);
        check("mrst/dist_vld", int'(dist_vld), 0, 0);
        check("mrst/timeout", int'(timeout), 0, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        wait_us(500);
        echo = 1'b0;
        wait_us(20);
        check("mrst/no_vld", vld_cnt - v0, 0, 0);
        check("mrst/no_timeout", to_cnt - t0, 0, 0);
        prev_us = 0;
        prev_mm = 0;
        rv = '{1'b0, 200, 1000, 1'b0, 1, 0, 1000, 171};
        run_vec(rv, "after_rst");

        // Random pulses checked against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            rv.pre_high = 1'b0;
            rv.delay_us = int'($urandom_range(800, 20));
            rv.width_us = int'($urandom_range(1500, 1));
            rv.mid_trig = 1'($urandom_range(1, 0));
            rv.exp_vld  = 1;
            rv.exp_to   = 0;
            rv.exp_us   = rv.width_us;
            rv.exp_mm   = model_mm(rv.width_us);
            run_vec(rv, $sformatf("rnd%0d_w%0d", i, rv.width_us));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
